audio_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for the voice-processing datapath, replacing the fixed 16-bit, 512-entry address-counter buffer in front of the window-coefficient RAM. It provides independent read/write pointers, full/empty/almost flags, an occupancy count, sticky error flags, a synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode. It sits between the audio sample source (I2S/ADC capture) and the framing/windowing/FFT stages.

---
 rtl/audio_sync_fifo.sv | 145 ++++++++++++++
 tb/tb_audio_sync_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sync_fifo.sv
// audio_sync_fifo: single-clock sample FIFO with standard or
// first-word-fall-through read, occupancy flags, sticky errors, flush.
module audio_sync_fifo #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AFULL_TH  = DEPTH - 4,
  parameter int unsigned AEMPTY_TH = 4,
  parameter bit          FWFT      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_TH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_TH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, empty_q;
  logic              afull_q, aempty_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q;

  logic wr_ok, rd_ok;
  logic mem_we, mem_re;
  logic bypass, load_rd;

  assign wr_ok = wr_en && !full_q;
  assign rd_ok = rd_en && !empty_q;

  always_comb begin
    level_d = level_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // In FWFT the head word lives in rdata_q; the array holds the rest.
  always_comb begin
    mem_we   = wr_ok;
    mem_re   = rd_ok;
    bypass   = 1'b0;
    rvalid_d = rd_ok;
    if (FWFT) begin
      bypass   = wr_ok &&
                 (empty_q || (rd_ok && level_q == LVL_ONE));
      mem_we   = wr_ok && !bypass;
      mem_re   = rd_ok && (level_q > LVL_ONE);
      rvalid_d = (level_d != '0);
    end
    load_rd = mem_re || bypass;
  end

  assign wr_ptr_d = mem_we ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = mem_re ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign ovf_d    = ovf_q || (wr_en && full_q);
  assign unf_d    = unf_q || (rd_en && empty_q);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_FULL);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= LVL_AF);
      aempty_q <= (level_d <= LVL_AE);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Flush leaves the output word untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (!clr && load_rd) begin
      rdata_q <= bypass ? wr_data : mem_q[rd_ptr_q];
    end
  end

  assign rd_data      = rdata_q;
  assign rd_valid     = rvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_audio_sync_fifo.sv
// tb_audio_sync_fifo: standard and FWFT instances driven in lockstep,
// each checked against a queue-based reference model.
module tb_audio_sync_fifo;

  localparam int DW = 16;
  localparam int D  = 8;
  localparam int AF = 4;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rv, s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic          f_rv, f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [3:0]    s_level, f_level;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_sync_fifo #(
    .DATA_W(DW), .DEPTH(D), .AFULL_TH(AF),
    .AEMPTY_TH(AE), .FWFT(1'b0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rv),
    .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae),
    .level(s_level), .overflow(s_ov), .underflow(s_un)
  );

  audio_sync_fifo #(
    .DATA_W(DW), .DEPTH(D), .AFULL_TH(AF),
    .AEMPTY_TH(AE), .FWFT(1'b1)
  ) u_fw (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rv),
    .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .level(f_level), .overflow(f_ov), .underflow(f_un)
  );

  logic [DW-1:0] sq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] s_exp_rd, f_exp_rd;
  logic          s_exp_rv, s_exp_ov, s_exp_un;
  logic          f_exp_ov, f_exp_un;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clr();
    sq.delete();
    fq.delete();
    s_exp_rv = 1'b0;
    s_exp_ov = 1'b0;
    s_exp_un = 1'b0;
    f_exp_ov = 1'b0;
    f_exp_un = 1'b0;
  endtask

  task automatic m_reset();
    m_clr();
    s_exp_rd = '0;
    f_exp_rd = '0;
  endtask

  task automatic m_step(input logic w, input logic r,
                        input logic [DW-1:0] d);
    int ss, fs;
    ss = sq.size();
    fs = fq.size();
    s_exp_rv = 1'b0;
    if (r) begin
      if (ss == 0) s_exp_un = 1'b1;
      else begin
        s_exp_rd = sq.pop_front();
        s_exp_rv = 1'b1;
      end
    end
    if (w) begin
      if (ss == D) s_exp_ov = 1'b1;
      else sq.push_back(d);
    end
    if (r) begin
      if (fs == 0) f_exp_un = 1'b1;
      else void'(fq.pop_front());
    end
    if (w) begin
      if (fs == D) f_exp_ov = 1'b1;
      else fq.push_back(d);
    end
    if (fq.size() != 0) f_exp_rd = fq[0];
  endtask

  task automatic compare_all();
    int ss, fs;
    ss = sq.size();
    fs = fq.size();
    chk("s_level", 32'(s_level), 32'(ss));
    chk("s_flags",
        {25'd0, s_full, s_empty, s_af, s_ae, s_rv, s_ov, s_un},
        {25'd0, ss == D, ss == 0, ss >= AF, ss <= AE,
         s_exp_rv, s_exp_ov, s_exp_un});
    chk("s_rdata", 32'(s_rd_data), 32'(s_exp_rd));
    chk("f_level", 32'(f_level), 32'(fs));
    chk("f_flags",
        {25'd0, f_full, f_empty, f_af, f_ae, f_rv, f_ov, f_un},
        {25'd0, fs == D, fs == 0, fs >= AF, fs <= AE,
         fs != 0, f_exp_ov, f_exp_un});
    chk("f_rdata", 32'(f_rd_data), 32'(f_exp_rd));
  endtask

  task automatic step(input logic c, input logic w, input logic r,
                      input logic [DW-1:0] d);
    clr = c;
    wr_en = w;
    rd_en = r;
    wr_data = d;
    @(posedge clk);
    if (c) m_clr();
    else m_step(w, r, d);
    #1;
    compare_all();
  endtask

  // Pulse reset between edges; outputs must clear before the next edge.
  task automatic arst();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int peak;
    logic saw_full;
    int pw, pr;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    chk("rst_out",
        {s_rd_data, s_rv, s_full, s_empty, s_ae, s_af, s_ov, s_un},
        {16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    peak = 0;
    saw_full = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, i >= 5, 16'(i));
      if (int'(s_level) > peak) peak = int'(s_level);
      saw_full = saw_full | s_full;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("fd_peak", 32'(peak), 32'd4);
    chk("fd_nofull", 32'(saw_full), 32'd0);
    chk("fd_last", 32'(s_rd_data), 32'h000C);

    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 9; i++)
      step(1'b0, 1'b1, 1'b0, 16'h00A0 + 16'(i));
    chk("fb_full", {s_full, s_ov, s_level}, {1'b1, 1'b1, 4'd8});
    step(1'b0, 1'b1, 1'b1, 16'h00FF);
    chk("fb_rd", {s_rv, s_rd_data, s_level},
        {1'b1, 16'h00A1, 4'd7});
    chk("fb_fw", {f_rd_data, f_level}, {16'h00A2, 4'd7});

    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 16'hBEEF);
    chk("eb_un", {s_un, s_rv, s_level}, {1'b1, 1'b0, 4'd1});
    step(1'b0, 1'b0, 1'b1, '0);
    chk("eb_rd", {s_rv, s_rd_data}, {1'b1, 16'hBEEF});
    step(1'b0, 1'b0, 1'b0, '0);
    chk("eb_pulse", 32'(s_rv), 32'd0);

    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 16'h1234);
    chk("fw_head", {f_rv, f_rd_data}, {1'b1, 16'h1234});
    step(1'b0, 1'b0, 1'b1, '0);
    chk("fw_pop", {f_rv, f_empty}, {1'b0, 1'b1});

    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 16'h0300 + 16'(i));
    chk("fl_af", {s_af, f_af}, 2'b11);
    step(1'b1, 1'b1, 1'b0, 16'h5555);
    chk("fl_clr", {s_level, s_empty, s_af, s_full, s_ov, s_un},
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 16'h0400 + 16'(i));
    arst();
    chk("ar_out", {s_level, f_level, s_empty, s_af, f_rv, s_rd_data},
        {4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0});

    pw = 50;
    pr = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        pw = int'($urandom_range(10, 90));
        pr = int'($urandom_range(10, 90));
      end
      if ($urandom_range(0, 399) == 0) arst();
      step($urandom_range(0, 99) == 0,
           int'($urandom_range(0, 99)) < pw,
           int'($urandom_range(0, 99)) < pr,
           16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
